// File: rtl/peripheral_arbiter_bb.sv
// Round-robin Wishbone arbiter letting NUM_MASTERS masters share one slave.
// Define ARBITER_WATCHDOG_EN to build in the hung-slave watchdog.
module peripheral_arbiter_bb #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 256
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
  output logic [NUM_MASTERS*DW-1:0]     m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic                          s_we_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  input  logic [DW-1:0]                 s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          timeout_o
);

  localparam int SW = DW / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   lastOwner_q, lastOwner_d;
  logic [IW-1:0]   winner;
  logic            wdogFire;

  logic [AW-1:0]   adrArr [NUM_MASTERS];
  logic [DW-1:0]   datArr [NUM_MASTERS];
  logic [SW-1:0]   selArr [NUM_MASTERS];
  logic [2:0]      ctiArr [NUM_MASTERS];
  logic [1:0]      bteArr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : gSlice
    assign adrArr[k] = m_adr_i[k*AW +: AW];
    assign datArr[k] = m_dat_i[k*DW +: DW];
    assign selArr[k] = m_sel_i[k*SW +: SW];
    assign ctiArr[k] = m_cti_i[k*3 +: 3];
    assign bteArr[k] = m_bte_i[k*2 +: 2];
  end

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    int            cand;
    logic [IW-1:0] candIdx;
    logic          found;
    winner  = lastOwner_q;
    found   = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand    = (int'(lastOwner_q) + i) % NUM_MASTERS;
      candIdx = IW'(cand);
      if (!found && m_cyc_i[candIdx]) begin
        found  = 1'b1;
        winner = candIdx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = OWNED;
          owner_d = winner;
        end
      end
      OWNED: begin
        if (!m_cyc_i[owner_q] || wdogFire) begin
          state_d     = IDLE;
          lastOwner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      lastOwner_q <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
    end
  end

  // Terminations are suppressed while reset is held so an aborted owner sees no ack.
  always_comb begin
    grant_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    if (state_q == OWNED) begin
      grant_o[owner_q] = 1'b1;
      s_adr_o = adrArr[owner_q];
      s_dat_o = datArr[owner_q];
      s_sel_o = selArr[owner_q];
      s_we_o  = m_we_i[owner_q];
      s_cyc_o = m_cyc_i[owner_q] && !wdogFire;
      s_stb_o = m_stb_i[owner_q] && !wdogFire;
      s_cti_o = ctiArr[owner_q];
      s_bte_o = bteArr[owner_q];
      if (!wb_rst_i) begin
        m_ack_o[owner_q] = s_ack_i;
        m_err_o[owner_q] = s_err_i || wdogFire;
        m_rty_o[owner_q] = s_rty_i;
      end
    end
  end

  assign m_dat_o = {NUM_MASTERS{s_dat_i}};

`ifdef ARBITER_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] wdogCount_q, wdogCount_d;
  logic          anyTerm;
  logic          stalled;

  assign anyTerm  = s_ack_i || s_err_i || s_rty_i;
  assign stalled  = (state_q == OWNED) && m_stb_i[owner_q] && !anyTerm;
  assign wdogFire = stalled && (wdogCount_q == CW'(TIMEOUT - 1));

  // Counts consecutive strobed cycles without a slave termination.
  always_comb begin
    wdogCount_d = '0;
    if (stalled && m_cyc_i[owner_q] && !wdogFire) begin
      wdogCount_d = wdogCount_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdogCount_q <= '0;
    end else begin
      wdogCount_q <= wdogCount_d;
    end
  end

  assign timeout_o = wdogFire;
`else
  assign wdogFire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_arbiter_bb.sv
// Self-checking bench for peripheral_arbiter_bb: directed scenarios plus
// randomized traffic compared against an integer-level arbitration model.
module tb_peripheral_arbiter_bb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 2;
  localparam int TO = 16;
`ifdef ARBITER_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NM*AW-1:0]     mAdr;
  logic [NM*DW-1:0]     mDat;
  logic [NM*DW/8-1:0]   mSel;
  logic [NM-1:0]        mWe, mCyc, mStb;
  logic [NM*3-1:0]      mCti;
  logic [NM*2-1:0]      mBte;
  logic [DW-1:0]        sDatIn;
  logic                 sAck, sErr, sRty;

  logic [NM*DW-1:0]     mDatOut;
  logic [NM-1:0]        mAckOut, mErrOut, mRtyOut;
  logic [AW-1:0]        sAdr;
  logic [DW-1:0]        sDat;
  logic [DW/8-1:0]      sSel;
  logic                 sWe, sCyc, sStb;
  logic [2:0]           sCti;
  logic [1:0]           sBte;
  logic [NM-1:0]        grant;
  logic                 timeoutOut;

  peripheral_arbiter_bb #(
    .AW(AW), .DW(DW), .NUM_MASTERS(NM), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),     .wb_rst_i(rst),
    .m_adr_i(mAdr),     .m_dat_i(mDat),     .m_sel_i(mSel),
    .m_we_i(mWe),       .m_cyc_i(mCyc),     .m_stb_i(mStb),
    .m_cti_i(mCti),     .m_bte_i(mBte),
    .m_dat_o(mDatOut),  .m_ack_o(mAckOut),  .m_err_o(mErrOut), .m_rty_o(mRtyOut),
    .s_adr_o(sAdr),     .s_dat_o(sDat),     .s_sel_o(sSel),    .s_we_o(sWe),
    .s_cyc_o(sCyc),     .s_stb_o(sStb),     .s_cti_o(sCti),    .s_bte_o(sBte),
    .s_dat_i(sDatIn),   .s_ack_i(sAck),     .s_err_i(sErr),    .s_rty_i(sRty),
    .grant_o(grant),    .timeout_o(timeoutOut)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: owner index (-1 = nobody), previous owner, stall counter.
  int modelOwner = -1;
  int modelLast  = NM - 1;
  int modelCount = 0;

  logic [NM-1:0] obsGrant, obsErr;
  logic          obsTimeout;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int rrPick(input int last, input logic [NM-1:0] req);
    for (int i = 1; i <= NM; i++) begin
      if (req[(last + i) % NM]) return (last + i) % NM;
    end
    return -1;
  endfunction

  // Checks every output at the falling edge, then advances the model on the rising edge.
  task automatic applyStimulus();
    logic [63:0] eGrant, eAdr, eDat, eSel, eWe, eCyc, eStb, eCti, eBte, eAck, eErr, eRty, eTo;
    bit own, fire, term;
    int o;
    @(negedge clk);
    own  = (modelOwner >= 0);
    o    = own ? modelOwner : 0;
    term = sAck || sErr || sRty;
    fire = WDOG && own && mStb[o] && !term && (modelCount == TO - 1);
    eGrant = 0; eAdr = 0; eDat = 0; eSel = 0; eWe = 0; eCyc = 0; eStb = 0;
    eCti = 0; eBte = 0; eAck = 0; eErr = 0; eRty = 0; eTo = 0;
    if (own) begin
      eGrant = 64'(1) << o;
      eAdr   = 64'(mAdr[o*AW +: AW]);
      eDat   = 64'(mDat[o*DW +: DW]);
      eSel   = 64'(mSel[o*4 +: 4]);
      eWe    = 64'(mWe[o]);
      eCyc   = 64'(mCyc[o] && !fire);
      eStb   = 64'(mStb[o] && !fire);
      eCti   = 64'(mCti[o*3 +: 3]);
      eBte   = 64'(mBte[o*2 +: 2]);
      eAck   = (sAck && !rst) ? (64'(1) << o) : 64'(0);
      eErr   = ((sErr || fire) && !rst) ? (64'(1) << o) : 64'(0);
      eRty   = (sRty && !rst) ? (64'(1) << o) : 64'(0);
      eTo    = 64'(fire);
    end
    checkOutput("grant",   64'(grant),      eGrant);
    checkOutput("s_adr",   64'(sAdr),       eAdr);
    checkOutput("s_dat",   64'(sDat),       eDat);
    checkOutput("s_sel",   64'(sSel),       eSel);
    checkOutput("s_we",    64'(sWe),        eWe);
    checkOutput("s_cyc",   64'(sCyc),       eCyc);
    checkOutput("s_stb",   64'(sStb),       eStb);
    checkOutput("s_cti",   64'(sCti),       eCti);
    checkOutput("s_bte",   64'(sBte),       eBte);
    checkOutput("m_ack",   64'(mAckOut),    eAck);
    checkOutput("m_err",   64'(mErrOut),    eErr);
    checkOutput("m_rty",   64'(mRtyOut),    eRty);
    checkOutput("timeout", 64'(timeoutOut), eTo);
    checkOutput("m_dat",   64'(mDatOut),    {sDatIn, sDatIn});
    obsGrant   = grant;
    obsErr     = mErrOut;
    obsTimeout = timeoutOut;
    @(posedge clk);
    if (rst) begin
      modelOwner = -1;
      modelLast  = NM - 1;
      modelCount = 0;
    end else if (modelOwner < 0) begin
      if (mCyc != '0) begin
        modelOwner = rrPick(modelLast, mCyc);
        modelCount = 0;
      end
    end else if (fire || !mCyc[modelOwner]) begin
      modelLast  = modelOwner;
      modelOwner = -1;
      modelCount = 0;
    end else if (mStb[modelOwner] && !term) begin
      modelCount++;
    end else begin
      modelCount = 0;
    end
    #1;
  endtask

  task automatic setMaster(input int k, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    mCyc[k] = cyc;
    mStb[k] = stb;
    mWe[k]  = we;
    mAdr[k*AW +: AW] = adr;
    mDat[k*DW +: DW] = dat;
    mSel[k*4 +: 4]   = 4'hF;
    mCti[k*3 +: 3]   = cti;
    mBte[k*2 +: 2]   = 2'b00;
  endtask

  task automatic setSlave(input logic ack, input logic err, input logic rty);
    sAck = ack;
    sErr = err;
    sRty = rty;
  endtask

  initial begin
    int firstTo;
    int waitCnt;
    int wantOwner;
    logic errSeen;

    rst = 1'b1;
    mAdr = '0; mDat = '0; mSel = '0; mWe = '0; mCyc = '0; mStb = '0; mCti = '0; mBte = '0;
    sDatIn = 32'h1234_5678;
    setSlave(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus();
    checkOutput("resetGrant", 64'(grant), 64'h0);
    checkOutput("resetTimeout", 64'(timeoutOut), 64'h0);
    rst = 1'b0;

    // Both request: master 0 first, single write, then master 1 after a dead cycle
    setMaster(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b000);
    setMaster(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 3'b000);
    applyStimulus();
    checkOutput("firstGrant", 64'(grant), 64'h1);
    setSlave(1'b1, 1'b0, 1'b0);
    applyStimulus();
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    setSlave(1'b0, 1'b0, 1'b0);
    applyStimulus();
    checkOutput("deadCycle", 64'(grant), 64'h0);
    applyStimulus();
    checkOutput("secondGrant", 64'(grant), 64'h2);

    // Master 1 burst is not preempted by master 0
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'b000);
    setSlave(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      setMaster(1, 1'b1, 1'b1, 1'b1, 32'h0000_0100 + 32'(4*b), 32'hA000_0000 + 32'(b),
                (b == 3) ? 3'b111 : 3'b010);
      applyStimulus();
      checkOutput("burstHold", 64'(grant), 64'h2);
    end
    setMaster(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    setSlave(1'b0, 1'b0, 1'b0);
    applyStimulus();
    checkOutput("burstRelease", 64'(grant), 64'h0);
    applyStimulus();
    checkOutput("afterBurst", 64'(grant), 64'h1);

    // Slave error routed to owner only; grant kept until cyc drops
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 3'b000);
    setMaster(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b000);
    setSlave(1'b0, 1'b1, 1'b0);
    applyStimulus();
    checkOutput("errOwnerOnly", 64'(obsErr), 64'h1);
    setSlave(1'b0, 1'b0, 1'b0);
    applyStimulus();
    checkOutput("errGrantKept", 64'(grant), 64'h1);
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    setMaster(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    applyStimulus();
    applyStimulus();

    // Reset during master 0 burst beat 2
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b010);
    applyStimulus();
    checkOutput("rstBurstGrant", 64'(grant), 64'h1);
    setSlave(1'b1, 1'b0, 1'b0);
    applyStimulus();
    mAdr[0 +: AW] = 32'h0000_0304;
    mCyc[1] = 1'b1;
    rst = 1'b1;
    applyStimulus();
    checkOutput("rstGrant", 64'(grant), 64'h0);
    checkOutput("rstCyc", 64'(sCyc), 64'h0);
    rst = 1'b0;
    setSlave(1'b0, 1'b0, 1'b0);
    applyStimulus();
    checkOutput("rstWinner", 64'(grant), 64'h1);

    // Continuous requests alternate owners 0,1,0,1,0,1
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 3'b000);
    setMaster(1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 3'b000);
    for (int t = 0; t < 6; t++) begin
      waitCnt = 0;
      while (grant == '0 && waitCnt < 5) begin
        applyStimulus();
        waitCnt++;
      end
      checkOutput("orderWait", 64'(grant != '0), 64'h1);
      wantOwner = t % 2;
      checkOutput("order", 64'(grant), 64'(1) << wantOwner);
      setSlave(1'b1, 1'b0, 1'b0);
      applyStimulus();
      mCyc[wantOwner] = 1'b0;
      setSlave(1'b0, 1'b0, 1'b0);
      applyStimulus();
      mCyc[wantOwner] = 1'b1;
    end

    // Hung slave
    rst = 1'b1;
    mCyc = '0;
    mStb = '0;
    applyStimulus();
    rst = 1'b0;
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 3'b000);
`ifdef ARBITER_WATCHDOG_EN
    firstTo = -1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      if (obsTimeout && firstTo < 0) firstTo = c;
    end
    checkOutput("wdogCycle", 64'(firstTo), 64'd16);
`else
    firstTo = -1;
    errSeen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      applyStimulus();
      if (obsErr != '0 || obsTimeout) errSeen = 1'b1;
    end
    checkOutput("noWdogErr", 64'(errSeen), 64'h0);
    checkOutput("hungGrant", 64'(grant), 64'h1);
`endif
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    applyStimulus();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int k = 0; k < NM; k++) begin
        if (mCyc[k]) mCyc[k] = ($urandom_range(0, 5) != 0);
        else         mCyc[k] = ($urandom_range(0, 2) == 0);
        mStb[k] = ($urandom_range(0, 3) != 0);
        mWe[k]  = 1'($urandom);
        mAdr[k*AW +: AW] = $urandom;
        mDat[k*DW +: DW] = $urandom;
        mSel[k*4 +: 4]   = 4'($urandom);
        mCti[k*3 +: 3]   = 3'($urandom);
        mBte[k*2 +: 2]   = 2'($urandom);
      end
      sDatIn = $urandom;
      r = $urandom_range(0, 9);
      setSlave(r < 5, r == 5, r == 6);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
